// File: rtl/barret421_rr_sched.sv
// rtl/barret421_rr_sched.sv - round-robin scheduler in front of a pipelined Barrett mod-421 reducer
// Optional counters stat_done/stat_stall are built when BARRET421_STATS_EN is defined.
module barret421_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*17-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [8:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready
`ifdef BARRET421_STATS_EN
  ,
  output logic [15:0]          stat_done,
  output logic [15:0]          stat_stall
`endif
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            s1_valid_q;
  logic [16:0]     s1_a_q;
  logic [ID_W-1:0] s1_id_q;

  logic            s2_valid_q;
  logic [16:0]     s2_a_q;
  logic [17:0]     s2_qh_q;
  logic [ID_W-1:0] s2_id_q;

  logic            s3_valid_q;
  logic [16:0]     s3_r0_q;
  logic [ID_W-1:0] s3_id_q;

  logic            rsp_valid_q;
  logic [8:0]      rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;

  logic               stall;
  logic               found;
  logic               xfer;
  logic [NUM_REQ-1:0] rot;
  int                 gsum;
  logic [ID_W-1:0]    gidx;
  logic [16:0]        a_in;

  logic [17:0] s1_qh;
  logic [8:0]  s2_t;
  logic [16:0] s2_prod;
  logic [16:0] s2_r0;
  logic [16:0] s3_r1;
  logic [16:0] s3_r;

  assign stall = rsp_valid_q & ~rsp_ready;

  // Rotate the valid vector so that bit 0 is the requester under the pointer.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    found = 1'b0;
    gsum  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        gsum  = int'(ptr_q) + k;
      end
    end
    if (gsum >= NUM_REQ) begin
      gsum = gsum - NUM_REQ;
    end
    gidx = ID_W'(gsum);
    xfer = found & ~stall & rst_n;

    req_ready = '0;
    a_in      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (gidx == ID_W'(i));
      if (gidx == ID_W'(i)) begin
        a_in = req_data[17*i +: 17];
      end
    end

    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
    end
  end

  // Quotient estimate t never exceeds floor(a/421) and undershoots by at most 2.
  always_comb begin
    s1_qh   = {10'd0, s1_a_q[16:9]} * 18'd622;
    s2_t    = 9'(s2_qh_q >> 9);
    s2_prod = {8'd0, s2_t} * 17'd421;
    s2_r0   = s2_a_q - s2_prod;
    s3_r1   = (s3_r0_q >= 17'd421) ? s3_r0_q - 17'd421 : s3_r0_q;
    s3_r    = (s3_r1 >= 17'd421) ? s3_r1 - 17'd421 : s3_r1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_qh_q     <= '0;
      s2_id_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_r0_q     <= '0;
      s3_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else if (!stall) begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= xfer;
      s1_a_q      <= a_in;
      s1_id_q     <= gidx;
      s2_valid_q  <= s1_valid_q;
      s2_a_q      <= s1_a_q;
      s2_qh_q     <= s1_qh;
      s2_id_q     <= s1_id_q;
      s3_valid_q  <= s2_valid_q;
      s3_r0_q     <= s2_r0;
      s3_id_q     <= s2_id_q;
      rsp_valid_q <= s3_valid_q;
      rsp_data_q  <= 9'(s3_r);
      rsp_id_q    <= s3_id_q;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef BARRET421_STATS_EN
  logic [15:0] stat_done_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        stat_done_q <= stat_done_q + 16'd1;
      end
      if (stall) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_done  = stat_done_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_barret421_rr_sched.sv
// tb/tb_barret421_rr_sched.sv - scoreboard bench for the round-robin Barrett mod-421 scheduler
module tb_barret421_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*17-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [8:0]            rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;
`ifdef BARRET421_STATS_EN
  logic [15:0]           stat_done;
  logic [15:0]           stat_stall;
`endif

  barret421_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef BARRET421_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int res;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   mptr = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit head_due();
    return (sb.size() > 0) && (sb[0].due <= cyc);
  endfunction

  // Request side: reference grant rule and scoreboard push.
  always @(negedge clk) begin
    if (rst_n) begin
      bit                 st;
      int                 g;
      logic [NUM_REQ-1:0] exp_rdy;
      exp_t               e;
      st      = head_due() && !rsp_ready;
      g       = -1;
      exp_rdy = '0;
      if (!st) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int idx;
          idx = (mptr + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
        e.id  = g;
        e.res = int'(req_data[17*g +: 17]) % 421;
        e.due = cyc + 4;
        sb.push_back(e);
        mptr = (g + 1) % NUM_REQ;
      end
    end
  end

  // Response side: pops and compares, and models the pipeline hold on backpressure.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      bit ev;
      ev = head_due();
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        check("rsp_data", 32'(rsp_data), sb[0].res);
        check("rsp_id", 32'(rsp_id), sb[0].id);
        if (rsp_ready) begin
          void'(sb.pop_front());
        end else begin
          foreach (sb[i]) sb[i].due = sb[i].due + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[17*i +: 17] = 17'($urandom);
  endtask

  task automatic drive_until_accept(input int id, input int a);
    bit got;
    req_valid[id]         = 1'b1;
    req_data[17*id +: 17] = 17'(a);
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int s0;
    int s1;
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    rsp_ready = 1'b1;
    #12;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
`ifdef BARRET421_STATS_EN
    check("reset_stat_done", 32'(stat_done), 32'd0);
    check("reset_stat_stall", 32'(stat_stall), 32'd0);
`endif
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();

    // Directed operands from requester 0, one at a time.
    drive_until_accept(0, 0);
    req_valid = '0;
    repeat (6) step();
    drive_until_accept(0, 420);
    req_valid = '0;
    repeat (6) step();
    drive_until_accept(0, 421);
    req_valid = '0;
    repeat (6) step();
    drive_until_accept(0, 131071);
    req_valid = '0;
    repeat (6) step();

    // Back-to-back sweep of both ends of the operand range from requester 2.
    for (int a = 0; a < 8192; a++) drive_until_accept(2, a);
    for (int a = 122880; a < 131072; a++) drive_until_accept(2, a);
    req_valid = '0;
    repeat (6) step();

    // All requesters valid: grants rotate.
    req_valid = '1;
    repeat (40) begin
      rand_data();
      step();
    end

    // Backpressure with a full pipeline.
`ifdef BARRET421_STATS_EN
    s0 = int'(stat_stall);
`else
    s0 = 0;
`endif
    rsp_ready = 1'b0;
    repeat (5) begin
      rand_data();
      step();
    end
    rsp_ready = 1'b1;
    step();
`ifdef BARRET421_STATS_EN
    s1 = int'(stat_stall);
    check("stat_stall_delta", 32'(s1 - s0), 32'd5);
`else
    s1 = s0;
`endif
    repeat (10) begin
      rand_data();
      step();
    end

    // Random valid masks and random backpressure.
    repeat (400) begin
      req_valid = NUM_REQ'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      rand_data();
      step();
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (6) begin
      rand_data();
      step();
    end

    // Reset with operations in flight.
    rst_n = 1'b0;
    sb.delete();
    mptr = 0;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_req_ready", 32'(req_ready), 32'd0);
    check("midreset_rsp_data", 32'(rsp_data), 32'd0);
    step();
    step();
    req_valid = 4'b1010;
    rst_n     = 1'b1;
    @(negedge clk);
    check("post_reset_first_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    repeat (12) begin
      rand_data();
      step();
    end

    req_valid = '0;
    repeat (10) step();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
